// File: rtl/vga_scan_fb.sv
// ---------------------------------------------------------------------------
// vga_scan_fb
//
// Parametrised VGA raster scanner. Walks a horizontal/vertical pixel raster
// at half the system clock rate, fetches each pixel's colour from a scaled
// framebuffer held in an external RAM with a 1-cycle registered read, and
// drives sync, display-enable and 24-bit colour towards the video DAC.
//
// Each framebuffer cell covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
// Cells are stored row-major: (H_ACTIVE >> SCALE_LOG2) cells per row.
//
// Optional feature macro: VGA_PALETTE_EN
//   undefined : rgb = {3{data[DATA_W-1 -: 8]}} (greyscale), no palette ports
//   defined   : 16 x 24-bit palette, rgb = pal[data[3:0]], palette write port
//
// Ports
//   clock_i        system clock (2x pixel rate)
//   reset_i        synchronous, active-high reset
//   data_i         framebuffer read data, valid one clock after addr_o
//   addr_o         framebuffer read address (0 during blanking)
//   vga_clock_o    pixel clock, clock_i / 2
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   blank_o        display enable: 1 = active video, 0 = blanking
//   rgb_o          {R,G,B}, forced to 0 while blank_o = 0
//   frame_start_o  one-clock pulse when the raster wraps to (0,0)
//   pal_we_i       palette write enable          (VGA_PALETTE_EN only)
//   pal_addr_i     palette write index           (VGA_PALETTE_EN only)
//   pal_wdata_i    palette write colour {R,G,B}  (VGA_PALETTE_EN only)
// ---------------------------------------------------------------------------
module vga_scan_fb #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 5,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 9
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              vga_clock_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              blank_o,
    output logic [23:0]       rgb_o,
    output logic              frame_start_o
`ifdef VGA_PALETTE_EN
    ,
    input  logic              pal_we_i,
    input  logic [3:0]        pal_addr_i,
    input  logic [23:0]       pal_wdata_i
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW      = $clog2(H_TOTAL);
    localparam int VCW      = $clog2(V_TOTAL);
    localparam int H_CELLS  = H_ACTIVE >> SCALE_LOG2;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic           vga_clk_q,     vga_clk_d;
    logic [HCW-1:0] h_cnt_q,       h_cnt_d;
    logic [VCW-1:0] v_cnt_q,       v_cnt_d;
    logic           hsync_q,       hsync_d;
    logic           vsync_q,       vsync_d;
    logic           blank_q,       blank_d;
    logic [23:0]    rgb_q,         rgb_d;
    logic           frame_start_q, frame_start_d;

    // Pixel tick: the edge at which the pixel clock is high (and falls).
    logic tick;
    logic h_last;
    logic v_last;
    logic active;
    logic [23:0] colour;

    assign tick   = vga_clk_q;
    assign h_last = (h_cnt_q == HCW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == VCW'(V_TOTAL - 1));
    assign active = (h_cnt_q < HCW'(H_ACTIVE)) && (v_cnt_q < VCW'(V_ACTIVE));

    // ------------------------------------------------------------------
    // Colour mapping of the word returned by the framebuffer
    // ------------------------------------------------------------------
`ifdef VGA_PALETTE_EN
    // Contents are deliberately not reset so a loaded palette survives a
    // mid-frame reset. Lookup is combinational into the rgb register, so a
    // write and a read of the same entry in one cycle sees the old value.
    logic [23:0] pal_q [16];

    always_ff @(posedge clock_i) begin
        if (pal_we_i) begin
            pal_q[pal_addr_i] <= pal_wdata_i;
        end
    end

    assign colour = pal_q[data_i[3:0]];
`else
    assign colour = {3{data_i[DATA_W-1 -: 8]}};
`endif

    // Not every framebuffer bit feeds the colour path in every build.
    logic unused_data;
    assign unused_data = ^data_i;

    // ------------------------------------------------------------------
    // Framebuffer address: combinational from the counters so the RAM can
    // register the read on the following (non-tick) edge.
    // ------------------------------------------------------------------
    always_comb begin
        addr_o = '0;
        if (active) begin
            addr_o = ADDR_W'(v_cnt_q >> SCALE_LOG2) * ADDR_W'(H_CELLS)
                   + ADDR_W'(h_cnt_q >> SCALE_LOG2);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        vga_clk_d     = ~vga_clk_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_d       = blank_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;

        if (tick) begin
            // Raster advance.
            if (h_last) begin
                h_cnt_d = '0;
                if (v_last) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + VCW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + HCW'(1);
            end

            frame_start_d = h_last && v_last;

            // Output stage for the pixel the counters held during the past
            // pixel period; data_i is that pixel's framebuffer word.
            blank_d = active;
            rgb_d   = active ? colour : 24'h0;
            hsync_d = !((h_cnt_q >= HCW'(HS_START)) && (h_cnt_q < HCW'(HS_END)));
            vsync_d = !((v_cnt_q >= VCW'(VS_START)) && (v_cnt_q < VCW'(VS_END)));
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vga_clk_q     <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b0;
            rgb_q         <= 24'h0;
            frame_start_q <= 1'b0;
        end else begin
            vga_clk_q     <= vga_clk_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_clock_o   = vga_clk_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign blank_o       = blank_q;
    assign rgb_o         = rgb_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_scan_fb.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_fb
//
// Self-checking bench for vga_scan_fb on a reduced raster (24 x 12 total,
// 16 x 8 active, 4x4-pixel cells -> 4 x 2 framebuffer cells) so that full
// frames fit in a short run. Expected outputs after every clock edge are
// derived from the edge count since reset release: even edges are pixel
// ticks, and after edge 2k the pins show raster pixel k-1. Frame-level
// totals (blank/sync clock counts, frame_start position) are checked against
// hand-computed constants. A one-clock reset mid-frame is also exercised.
// ---------------------------------------------------------------------------
module tb_vga_scan_fb;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int SL = 2;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 12
    localparam int FT = HT * VT;               // 288 pixels per frame
    localparam int HC = HA >> SL;              // 4 cells per row

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          vga_clock;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic [23:0]   rgb;
    logic          frame_start;
`ifdef VGA_PALETTE_EN
    logic          pal_we;
    logic [3:0]    pal_addr;
    logic [23:0]   pal_wdata;
    logic [23:0]   pal_model [16];
`endif

    always #5 clk = ~clk;

    vga_scan_fb #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SCALE_LOG2(SL), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .data_i       (data),
        .addr_o       (addr),
        .vga_clock_o  (vga_clock),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .blank_o      (blank),
        .rgb_o        (rgb),
        .frame_start_o(frame_start)
`ifdef VGA_PALETTE_EN
        ,
        .pal_we_i     (pal_we),
        .pal_addr_i   (pal_addr),
        .pal_wdata_i  (pal_wdata)
`endif
    );

    // Framebuffer RAM model with 1-cycle registered read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) data <= mem[addr];

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level accumulators (first frame after a reset release).
    int blank_clks, hs_low_clks, vs_low_clks, fs_pulses, fs_first;

    task automatic check_eq(input string tag, input int n,
                            input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, n, got, exp);
    endtask

    function automatic logic [23:0] colour_of(input logic [7:0] d);
`ifdef VGA_PALETTE_EN
        return pal_model[d[3:0]];
`else
        return {d, d, d};
`endif
    endfunction

    // Checks all pins after clock edge n since reset release (n >= 1) and
    // accumulates frame totals for edges within the first frame.
    task automatic check_edge(input int n);
        int k, p, h, v, ka, ha, va;
        logic act, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        logic [AW-1:0] e_addr;
        k = n / 2;
        if (k == 0) begin
            act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h0;
        end else begin
            p = (k - 1) % FT;
            h = p % HT;
            v = p / HT;
            act   = (h < HA) && (v < VA);
            e_hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
            e_vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
            e_rgb = act ? colour_of(mem[(v >> SL) * HC + (h >> SL)]) : 24'h0;
        end
        ka = k % FT;
        ha = ka % HT;
        va = ka / HT;
        e_addr = ((ha < HA) && (va < VA)) ? AW'((va >> SL) * HC + (ha >> SL)) : '0;
        e_fs   = (n % 2 == 0) && (k > 0) && (k % FT == 0);

        check_eq("vga_clock",   n, 32'(vga_clock),   32'(n % 2));
        check_eq("hsync",       n, 32'(hsync),       32'(e_hs));
        check_eq("vsync",       n, 32'(vsync),       32'(e_vs));
        check_eq("blank",       n, 32'(blank),       32'(act));
        check_eq("rgb",         n, 32'(rgb),         32'(e_rgb));
        check_eq("addr",        n, 32'(addr),        32'(e_addr));
        check_eq("frame_start", n, 32'(frame_start), 32'(e_fs));

        if (n <= 2 * FT) begin
            if (blank)  blank_clks++;
            if (!hsync) hs_low_clks++;
            if (!vsync) vs_low_clks++;
        end
        if (frame_start) begin
            fs_pulses++;
            if (fs_first < 0) fs_first = n;
        end
        if (n % (2 * HT) == 0)
            $display("line %0d scanned (edge %0d) hsync=%0b vsync=%0b",
                     n / (2 * HT) - 1, n, hsync, vsync);
    endtask

    task automatic run_edges(input int count);
        blank_clks = 0; hs_low_clks = 0; vs_low_clks = 0;
        fs_pulses = 0;  fs_first = -1;
        for (int n = 1; n <= count; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_edge(n);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_vga_clock"},   0, 32'(vga_clock),   32'd0);
        check_eq({tag, "_hsync"},       0, 32'(hsync),       32'd1);
        check_eq({tag, "_vsync"},       0, 32'(vsync),       32'd1);
        check_eq({tag, "_blank"},       0, 32'(blank),       32'd0);
        check_eq({tag, "_rgb"},         0, 32'(rgb),         32'd0);
        check_eq({tag, "_addr"},        0, 32'(addr),        32'd0);
        check_eq({tag, "_frame_start"}, 0, 32'(frame_start), 32'd0);
    endtask

    initial begin
        // Cells 0..7 get distinct values with distinct low nibbles; unused
        // locations hold a sentinel that must never reach rgb.
        for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? 8'(i * 17 + 3) : 8'hEE;
        rst = 1'b1;
`ifdef VGA_PALETTE_EN
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
        for (int i = 0; i < 16; i++)
            pal_model[i] = {8'(i * 16), 8'(255 - i * 8), 8'hC3 ^ 8'(i)};
`endif
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_hold");

`ifdef VGA_PALETTE_EN
        // Palette loads while reset is held; contents are not reset.
        for (int i = 0; i < 16; i++) begin
            pal_we = 1'b1; pal_addr = 4'(i); pal_wdata = pal_model[i];
            @(negedge clk);
        end
        pal_we = 1'b0;
`endif

        // Release and scan a full frame plus part of the next, stopping with
        // the counters at h=5, v=3 of the second frame (pixel 77).
        rst = 1'b0;
        run_edges(2 * FT + 2 * 77);
        check_eq("blank_clks_frame",  0, 32'(blank_clks),  32'(2 * HA * VA));     // 256
        check_eq("hsync_low_frame",   0, 32'(hs_low_clks), 32'(2 * HS * VT));     // 72
        check_eq("vsync_low_frame",   0, 32'(vs_low_clks), 32'(2 * VS * HT));     // 96
        check_eq("frame_start_first", 0, 32'(fs_first),    32'(2 * FT));          // 576
        check_eq("frame_start_count", 0, 32'(fs_pulses),   32'd1);
        check_eq("addr_pre_reset",    0, 32'(addr),        32'd1);

        // One-clock reset mid-frame.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;
        run_edges(2 * FT + 24);
        check_eq("restart_frame_start_first", 0, 32'(fs_first),  32'(2 * FT));
        check_eq("restart_frame_start_count", 0, 32'(fs_pulses), 32'd1);
        check_eq("restart_blank_clks",        0, 32'(blank_clks), 32'(2 * HA * VA));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_fb.md
# vga_scan_fb

Parametrised VGA raster scanner that reads a scaled framebuffer from an external synchronous memory and drives sync, display-enable and 24-bit colour to the DAC. It generalises the fixed 640x480 memory-to-VGA scanner: all timing fields, framebuffer cell scaling and memory widths are parameters, and an optional colour palette can be compiled in. It sits between the framebuffer RAM (1-cycle registered read) and the video DAC pins.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixel ticks
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync lengths in lines
- SCALE_LOG2, 5, each framebuffer cell covers 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels (0 = 1:1)
- DATA_W, 8, framebuffer word width (>= 8)
- ADDR_W, 9, framebuffer address width; must hold (H_ACTIVE>>SCALE_LOG2)*(V_ACTIVE>>SCALE_LOG2)-1

Ports:
- clock  in  1  system clock (2x pixel rate)
- reset  in  1  synchronous, active-high
- data  in  DATA_W  framebuffer read data, valid one clock after addr
- addr  out  ADDR_W  framebuffer read address
- vga_clock  out  1  pixel clock, clock/2
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank  out  1  display enable: 1 = active video, 0 = blanking
- rgb  out  24  {R,G,B}, 0 while blank=0
- frame_start  out  1  one-clock pulse when the raster wraps to (0,0)
- pal_we / pal_addr[3:0] / pal_wdata[23:0]  in  palette write port (present only with VGA_PALETTE_EN)

## Operation
- vga_clock: register, reset 0, toggles every clock. A pixel tick is a clock edge at which vga_clock==1 (vga_clock falls at that edge).
- h_cnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), increments per pixel tick, wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL likewise. Both widths sized by $clog2 of totals.
- Active region h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. Sync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), likewise vertical on v_cnt.
- addr (combinational from counters): active -> (v_cnt>>SCALE_LOG2)*(H_ACTIVE>>SCALE_LOG2) + (h_cnt>>SCALE_LOG2); blanking -> 0. Multiply by constant; no truncation allowed beyond ADDR_W check.
- Colour: default rgb = {3{data[DATA_W-1 -: 8]}} (greyscale).
- hsync/vsync/blank pass through one pixel-tick delay stage so they align with rgb.
- frame_start pulses at the pixel tick where (h_cnt,v_cnt) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0).
- Reset values: vga_clock 0, counters 0, hsync 1, vsync 1, blank 0, rgb 0, addr 0 (counters at 0), frame_start 0.
- Reset mid-frame: all state returns to reset values at the next edge; raster restarts at (0,0), no partial-line output, palette contents retained.

## Timing
- Edge E0: counters reach pixel P; addr(P) valid after E0. E1 (vga_clock 0->1): memory registers data(P). E2 (next pixel tick): rgb, blank, hsync, vsync for P registered together.
- Pipeline latency counters->pins: exactly 2 clocks (1 pixel tick); all outputs change only on pixel ticks, except vga_clock and frame_start.
- After reset deassertion, pixel (0,0) appears on rgb after the 2nd clock edge.
- Line = 2*H_TOTAL clocks; frame = 2*H_TOTAL*V_TOTAL clocks (defaults 1600 / 840000).

## Configuration
- VGA_PALETTE_EN defined: 16x24-bit palette register file, reset not applied to contents (undefined until written); pal_we writes pal_wdata at pal_addr on the clock edge; rgb = pal[data[3:0]]; write and read of same entry in one cycle returns old value. Lookup adds no latency (combinational read into rgb register).
- Undefined: palette ports absent, greyscale mapping as above.

## Test plan
- Defaults, reset released at t0 -> vga_clock toggles every clock; first active blank=1 with rgb from mem[0] after 2nd edge; hsync/vsync/blank/rgb = 1/1/0/0 while reset held.
- Line timing -> blank high 1280 clocks per line; hsync low for exactly 192 clocks starting 1312 clocks after line start; line period 1600 clocks.
- Frame timing -> 480 active lines, vsync low for 3200 clocks, frame_start pulses once per 840000 clocks and is 1 clock wide.
- SCALE_LOG2=5, mem[k]=k (greyscale) -> addr constant over 32 pixels, row stride 20, last active pixel addr 299; rgb = {3{k}}; blanking addr=0, rgb=0.
- VGA_PALETTE_EN, write pal[3]=24'hFF8000, framebuffer all 3 -> every active pixel rgb=24'hFF8000; without macro rgb=24'h030303.
- Reset pulsed 1 clock at h_cnt=300, v_cnt=100 -> next edge all outputs at reset values; raster restarts at (0,0) and frame_start next fires 840000 clocks later.
